// File: rtl/jtexterm_romarb_pkg.sv
// Shared types and limits for the ROM request arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package jtexterm_romarb_pkg;

    localparam int NMAX = 8;   // largest supported client count
    localparam int PTRW = 3;   // enough bits to index NMAX clients

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/jtexterm_rr_pick.sv
// Combinational round-robin picker: first pending client at or after ptr.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the winner is consumed.
//
// Ports:
//   pend - per-client pending request vector
//   ptr  - index of the highest-priority client this round (0..N-1)
//   win  - one-hot winner, all zero when nothing is pending
//   idx  - binary index of the winner (0 when nothing is pending)
//   any  - at least one client is pending
module jtexterm_rr_pick
    import jtexterm_romarb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]    pend,
    input  logic [PTRW-1:0] ptr,
    output logic [N-1:0]    win,
    output logic [PTRW-1:0] idx,
    output logic            any
);

    always_comb begin
        int           j;
        logic [N-1:0] mask;
        win  = '0;
        idx  = '0;
        any  = 1'b0;
        j    = 0;
        mask = '0;
        // Walk the clients starting at ptr, wrapping at N; first hit wins.
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            mask = N'(1) << j;
            if (!any && (|(pend & mask))) begin
                any = 1'b1;
                win = mask;
                idx = PTRW'(j);
            end
        end
    end

endmodule

// File: rtl/jtexterm_romarb.sv
// N-client ROM read arbiter onto one SDRAM read port, round-robin, one request in flight.
// Latency: miss -> ok after IDLE+REQ+WAIT (3 cycles minimum); hit -> ok in the same cycle.
// Backpressure: sdram_req held with a stable address until sdram_ack; clients wait on ok.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   cs, addr            - per-client request and absolute word address (client i at [i*AW +: AW])
//   ok, data            - per-client data valid for current addr, and result word (client i at [i*DW +: DW])
//   sdram_req/addr/ack  - read request handshake towards the SDRAM controller
//   sdram_rdy/din       - one-cycle read data strobe from the SDRAM controller
//   grant               - one-hot client being served, zero when idle
//
// Build option: define JTEXTERM_ROMARB_CACHE_EN to keep each client's last word
// across cs deassertion; otherwise a client's result is dropped whenever its cs is low.
module jtexterm_romarb
    import jtexterm_romarb_pkg::*;
#(
    parameter int N  = 3,
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    cs,
    input  logic [N*AW-1:0] addr,
    output logic [N-1:0]    ok,
    output logic [N*DW-1:0] data,
    output logic            sdram_req,
    output logic [AW-1:0]   sdram_addr,
    input  logic            sdram_ack,
    input  logic            sdram_rdy,
    input  logic [DW-1:0]   sdram_din,
    output logic [N-1:0]    grant
);

    state_t          state, state_nxt;
    logic [N-1:0]    hit;
    logic [N-1:0]    pend;
    logic [N-1:0]    win;
    logic [PTRW-1:0] win_idx;
    logic [PTRW-1:0] gnt_idx;
    logic [PTRW-1:0] ptr;
    logic            any_pend;
    logic            load;     // IDLE and a winner exists: capture request
    logic            done;     // WAIT and read data arrived: retire request

    // The client being served is excluded so it cannot win again while its
    // own transaction is still in flight.
    assign pend = cs & ~hit & ~grant;

    jtexterm_rr_pick #(
        .N (N)
    ) u_pick (
        .pend (pend),
        .ptr  (ptr),
        .win  (win),
        .idx  (win_idx),
        .any  (any_pend)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; rdy outside WAIT is simply never looked at.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_pend)  state_nxt = REQ;
            REQ:     if (sdram_ack) state_nxt = WAIT;
            WAIT:    if (sdram_rdy) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Output / strobe decode
    always_comb begin
        sdram_req = 1'b0;
        load      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    load      = any_pend;
            REQ:     sdram_req = 1'b1;
            WAIT:    done      = sdram_rdy;
            default: ;
        endcase
    end

    // Request datapath: address, grant and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdram_addr <= '0;
            grant      <= '0;
            gnt_idx    <= '0;
            ptr        <= '0;
        end else if (load) begin
            sdram_addr <= addr[win_idx*AW +: AW];
            grant      <= win;
            gnt_idx    <= win_idx;
        end else if (done) begin
            grant <= '0;
            ptr   <= (gnt_idx == PTRW'(N - 1)) ? '0 : gnt_idx + PTRW'(1);
        end
    end

    // Per-client result registers
    for (genvar i = 0; i < N; i++) begin : g_client
        logic [AW-1:0] tag;
        logic [DW-1:0] dreg;
        logic          valid;
        logic          wr;
        logic          valid_set;
        logic          valid_clr;

        assign wr = done & grant[i];

`ifdef JTEXTERM_ROMARB_CACHE_EN
        assign valid_set = 1'b1;
        assign valid_clr = 1'b0;
`else
        // A completion for a client that already let go of cs is not kept.
        assign valid_set = cs[i];
        assign valid_clr = ~cs[i];
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tag   <= '0;
                dreg  <= '0;
                valid <= 1'b0;
            end else if (wr) begin
                // Tag is the address actually fetched, not the client's
                // current one, so a moved address misses and re-arbitrates.
                tag   <= sdram_addr;
                dreg  <= sdram_din;
                valid <= valid_set;
            end else if (valid_clr) begin
                valid <= 1'b0;
            end
        end

        assign hit[i]            = cs[i] & valid & (tag == addr[i*AW +: AW]);
        assign data[i*DW +: DW]  = dreg;
    end

    assign ok = hit;

endmodule

// File: tb/tb_jtexterm_romarb.sv
module tb_jtexterm_romarb;

    localparam int N  = 3;
    localparam int AW = 22;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    cs = '0;
    logic [AW-1:0]   a0 = '0, a1 = '0, a2 = '0;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    ok;
    logic [N*DW-1:0] data;
    logic            sdram_req;
    logic [AW-1:0]   sdram_addr;
    logic            sdram_ack = 1'b0;
    logic            sdram_rdy = 1'b0;
    logic [DW-1:0]   sdram_din = '0;
    logic [N-1:0]    grant;
    logic [DW-1:0]   d0, d1, d2;

    int total = 0;
    int bad   = 0;

    assign addr = {a2, a1, a0};
    assign d0   = data[0*DW +: DW];
    assign d1   = data[1*DW +: DW];
    assign d2   = data[2*DW +: DW];

    always #5 clk = ~clk;

    jtexterm_romarb #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .addr       (addr),
        .ok         (ok),
        .data       (data),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_din  (sdram_din),
        .grant      (grant)
    );

    typedef struct {
        logic [N-1:0]  cs;
        logic [AW-1:0] a0, a1, a2;
        logic          ack, rdy;
        logic [DW-1:0] din;
        logic [N-1:0]  e_ok;
        logic          e_req;
        logic [N-1:0]  e_gnt;
        logic [AW-1:0] e_saddr;
        logic [DW-1:0] e_d0;
    } vec_t;

    vec_t miss_v[$];
    vec_t rr_v[$];

    function automatic vec_t mk(input logic [N-1:0] c, input logic [AW-1:0] x0, x1, x2,
                                input logic k, r, input logic [DW-1:0] d,
                                input logic [N-1:0] eo, input logic er, input logic [N-1:0] eg,
                                input logic [AW-1:0] es, input logic [DW-1:0] ed);
        vec_t v;
        v.cs = c; v.a0 = x0; v.a1 = x1; v.a2 = x2; v.ack = k; v.rdy = r; v.din = d;
        v.e_ok = eo; v.e_req = er; v.e_gnt = eg; v.e_saddr = es; v.e_d0 = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge; outputs are sampled
    // by the caller mid-low-phase, well away from the rising edge.
    task automatic cyc(input logic [N-1:0] c, input logic [AW-1:0] x0, x1, x2,
                       input logic k, r, input logic [DW-1:0] d);
        @(negedge clk);
        cs = c; a0 = x0; a1 = x1; a2 = x2;
        sdram_ack = k; sdram_rdy = r; sdram_din = d;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cs = '0; a0 = '0; a1 = '0; a2 = '0;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_din = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_table(input string tag, input vec_t tv[$]);
        for (int i = 0; i < tv.size(); i++) begin
            cyc(tv[i].cs, tv[i].a0, tv[i].a1, tv[i].a2, tv[i].ack, tv[i].rdy, tv[i].din);
            chk($sformatf("%s[%0d] ok", tag, i),    ok,         tv[i].e_ok);
            chk($sformatf("%s[%0d] req", tag, i),   sdram_req,  tv[i].e_req);
            chk($sformatf("%s[%0d] grant", tag, i), grant,      tv[i].e_gnt);
            chk($sformatf("%s[%0d] saddr", tag, i), sdram_addr, tv[i].e_saddr);
            chk($sformatf("%s[%0d] data0", tag, i), d0,         tv[i].e_d0);
        end
    endtask

    initial begin
        // Single miss: req at 1, ack at 1, rdy at 2, ok at 3; no re-request on hit.
        miss_v.push_back(mk(3'b001, 22'h1234, 0, 0, 0, 0, 0,            3'b000, 0, 3'b000, 22'h0,    32'h0));
        miss_v.push_back(mk(3'b001, 22'h1234, 0, 0, 1, 0, 0,            3'b000, 1, 3'b001, 22'h1234, 32'h0));
        miss_v.push_back(mk(3'b001, 22'h1234, 0, 0, 0, 1, 32'hDEADBEEF, 3'b000, 0, 3'b001, 22'h1234, 32'h0));
        miss_v.push_back(mk(3'b001, 22'h1234, 0, 0, 0, 0, 0,            3'b001, 0, 3'b000, 22'h1234, 32'hDEADBEEF));
        miss_v.push_back(mk(3'b001, 22'h1234, 0, 0, 0, 0, 0,            3'b001, 0, 3'b000, 22'h1234, 32'hDEADBEEF));

        // Round robin from ptr=0: 001, 010, 100, then 001 again with fresh addresses.
        rr_v.push_back(mk(3'b111, 22'h100, 22'h101, 22'h102, 0, 0, 0,            3'b000, 0, 3'b000, 22'h0,   32'h0));
        rr_v.push_back(mk(3'b111, 22'h100, 22'h101, 22'h102, 1, 0, 0,            3'b000, 1, 3'b001, 22'h100, 32'h0));
        rr_v.push_back(mk(3'b111, 22'h100, 22'h101, 22'h102, 0, 1, 32'hA0A00000, 3'b000, 0, 3'b001, 22'h100, 32'h0));
        rr_v.push_back(mk(3'b111, 22'h100, 22'h101, 22'h102, 0, 0, 0,            3'b001, 0, 3'b000, 22'h100, 32'hA0A00000));
        rr_v.push_back(mk(3'b111, 22'h200, 22'h101, 22'h102, 1, 0, 0,            3'b000, 1, 3'b010, 22'h101, 32'hA0A00000));
        rr_v.push_back(mk(3'b111, 22'h200, 22'h101, 22'h102, 0, 1, 32'hA1A10001, 3'b000, 0, 3'b010, 22'h101, 32'hA0A00000));
        rr_v.push_back(mk(3'b111, 22'h200, 22'h101, 22'h102, 0, 0, 0,            3'b010, 0, 3'b000, 22'h101, 32'hA0A00000));
        rr_v.push_back(mk(3'b111, 22'h200, 22'h201, 22'h102, 1, 0, 0,            3'b000, 1, 3'b100, 22'h102, 32'hA0A00000));
        rr_v.push_back(mk(3'b111, 22'h200, 22'h201, 22'h102, 0, 1, 32'hA2A20002, 3'b000, 0, 3'b100, 22'h102, 32'hA0A00000));
        rr_v.push_back(mk(3'b111, 22'h200, 22'h201, 22'h102, 0, 0, 0,            3'b100, 0, 3'b000, 22'h102, 32'hA0A00000));
        rr_v.push_back(mk(3'b111, 22'h200, 22'h201, 22'h202, 1, 0, 0,            3'b000, 1, 3'b001, 22'h200, 32'hA0A00000));
        rr_v.push_back(mk(3'b111, 22'h200, 22'h201, 22'h202, 0, 1, 32'hB0B00000, 3'b000, 0, 3'b001, 22'h200, 32'hA0A00000));
        rr_v.push_back(mk(3'b000, 22'h200, 22'h201, 22'h202, 0, 0, 0,            3'b000, 0, 3'b000, 22'h200, 32'hB0B00000));

        do_reset();
        run_table("miss", miss_v);
        do_reset();
        run_table("rr", rr_v);

        // Address change while in WAIT: stale word is stored, client re-requests.
        do_reset();
        cyc(3'b010, 0, 22'h10, 0, 0, 0, 0);
        cyc(3'b010, 0, 22'h10, 0, 1, 0, 0);
        chk("aw req", sdram_req, 1'b1);
        chk("aw saddr", sdram_addr, 22'h10);
        cyc(3'b010, 0, 22'h20, 0, 0, 1, 32'h11);
        chk("aw ok in wait", ok, 3'b000);
        cyc(3'b010, 0, 22'h20, 0, 0, 0, 0);
        chk("aw ok stale tag", ok, 3'b000);
        chk("aw data1 stale", d1, 32'h11);
        cyc(3'b010, 0, 22'h20, 0, 1, 0, 0);
        chk("aw req2", sdram_req, 1'b1);
        chk("aw saddr2", sdram_addr, 22'h20);
        chk("aw grant2", grant, 3'b010);
        cyc(3'b010, 0, 22'h20, 0, 0, 1, 32'h22);
        cyc(3'b010, 0, 22'h20, 0, 0, 0, 0);
        chk("aw ok final", ok, 3'b010);
        chk("aw data1 final", d1, 32'h22);

        // Drop cs and re-raise with the same address.
        cyc(3'b000, 0, 22'h20, 0, 0, 0, 0);
        chk("cache ok cs low", ok, 3'b000);
        cyc(3'b010, 0, 22'h20, 0, 0, 0, 0);
`ifdef JTEXTERM_ROMARB_CACHE_EN
        chk("cache ok reassert", ok, 3'b010);
        cyc(3'b010, 0, 22'h20, 0, 0, 0, 0);
        chk("cache no req", sdram_req, 1'b0);
`else
        chk("nocache ok reassert", ok, 3'b000);
        cyc(3'b010, 0, 22'h20, 0, 0, 0, 0);
        chk("nocache req", sdram_req, 1'b1);
        chk("nocache saddr", sdram_addr, 22'h20);
`endif

        // Ack stretch with a stray rdy during REQ.
        do_reset();
        cyc(3'b100, 0, 0, 22'h3ABCD, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(3'b100, 0, 0, 22'h3ABCD, 0, (k == 2), 32'hBAD0BAD0);
            chk($sformatf("st[%0d] req", k), sdram_req, 1'b1);
            chk($sformatf("st[%0d] saddr", k), sdram_addr, 22'h3ABCD);
            chk($sformatf("st[%0d] grant", k), grant, 3'b100);
            chk($sformatf("st[%0d] ok", k), ok, 3'b000);
        end
        cyc(3'b100, 0, 0, 22'h3ABCD, 1, 0, 0);
        chk("st ack req", sdram_req, 1'b1);
        cyc(3'b100, 0, 0, 22'h3ABCD, 0, 1, 32'h55);
        chk("st wait req", sdram_req, 1'b0);
        chk("st wait grant", grant, 3'b100);
        cyc(3'b100, 0, 0, 22'h3ABCD, 0, 0, 0);
        chk("st ok", ok, 3'b100);
        chk("st data2", d2, 32'h55);
        chk("st no req after rdy", sdram_req, 1'b0);

        // Reset mid-WAIT after moving ptr off client 0.
        do_reset();
        cyc(3'b010, 0, 22'h77, 0, 0, 0, 0);
        cyc(3'b010, 0, 22'h77, 0, 1, 0, 0);
        cyc(3'b010, 0, 22'h77, 0, 0, 1, 32'h1);
        cyc(3'b100, 0, 0, 22'h78, 0, 0, 0);
        chk("rw ok idle", ok, 3'b000);
        cyc(3'b100, 0, 0, 22'h78, 1, 0, 0);
        chk("rw req", sdram_req, 1'b1);
        chk("rw grant", grant, 3'b100);
        @(negedge clk);
        rst = 1'b1; cs = '0; sdram_ack = 1'b0;
        #1;
        chk("rw rst req", sdram_req, 1'b0);
        chk("rw rst grant", grant, 3'b000);
        chk("rw rst saddr", sdram_addr, 22'h0);
        chk("rw rst ok", ok, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        cyc(3'b111, 22'h300, 22'h301, 22'h302, 0, 1, 32'hEE);
        chk("rw late rdy req", sdram_req, 1'b0);
        chk("rw late rdy grant", grant, 3'b000);
        chk("rw late rdy ok", ok, 3'b000);
        cyc(3'b111, 22'h300, 22'h301, 22'h302, 0, 0, 0);
        chk("rw next grant", grant, 3'b001);
        chk("rw next req", sdram_req, 1'b1);
        chk("rw next saddr", sdram_addr, 22'h300);
        chk("rw next ok", ok, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
